alu_seq: RTL and testbench

- Parametrised, handshaked successor to the 8-bit datapath ALU. It registers every result and holds persistent status flags.
- Adds carry-chained add/subtract, shifts, signed overflow and negative flags, and an iterative shift-add multiplier.
- Sits between the register-file read ports and the writeback stage of the microprocessor core. It drives condition flags to the branch unit.

---
 rtl/alu_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with persistent status flags and an iterative shift-add multiplier.
// Results and flags update together when a result enters DONE; out_valid/busy decode the state register.
module alu_seq #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_err,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_neg,
  output logic             flag_ovf,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [3:0] M_ADD = 4'd0;
  localparam logic [3:0] M_SUB = 4'd1;
  localparam logic [3:0] M_ADC = 4'd2;
  localparam logic [3:0] M_SBB = 4'd3;
  localparam logic [3:0] M_CMP = 4'd4;
  localparam logic [3:0] M_AND = 4'd5;
  localparam logic [3:0] M_OR  = 4'd6;
  localparam logic [3:0] M_XOR = 4'd7;
  localparam logic [3:0] M_NOT = 4'd8;
  localparam logic [3:0] M_SHL = 4'd9;
  localparam logic [3:0] M_SHR = 4'd10;
  localparam logic [3:0] M_SAR = 4'd11;
  localparam logic [3:0] M_MUL = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_BUSY = 2'd1,
    S_DONE     = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_hi;
  logic               r_err;
  logic               r_flag_zero;
  logic               r_flag_carry;
  logic               r_flag_neg;
  logic               r_flag_ovf;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand;
  logic [CW-1:0]      r_cnt;

  logic               w_accept;
  logic               w_cin;
  logic [SW-1:0]      w_shamt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_shl;
  logic [WIDTH:0]     w_shr;
  logic [WIDTH:0]     w_sar;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_zn;
  logic               w_c;
  logic               w_v;
  logic               w_err;
  logic               w_is_mul;
  logic [WIDTH:0]     w_mac;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               w_mul_last;

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_MUL_BUSY);

  assign out_data   = r_data;
  assign out_hi     = r_hi;
  assign out_err    = r_err;
  assign flag_zero  = r_flag_zero;
  assign flag_carry = r_flag_carry;
  assign flag_neg   = r_flag_neg;
  assign flag_ovf   = r_flag_ovf;

  // Carry/borrow-in only for the chained modes; taken from the flag register at accept.
  assign w_cin   = ((in_mode == M_ADC) || (in_mode == M_SBB)) ? r_flag_carry : 1'b0;
  assign w_shamt = in_b[SW-1:0];
  assign w_sum   = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff  = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, w_cin};

  // One guard bit beyond the operand catches the last bit shifted out (0 for a zero shift).
  assign w_shl = {1'b0, in_a} << w_shamt;
  assign w_shr = {in_a, 1'b0} >> w_shamt;
  assign w_sar = $unsigned($signed({in_a, 1'b0}) >>> w_shamt);

  always_comb begin
    w_res    = '0;
    w_c      = 1'b0;
    w_v      = 1'b0;
    w_err    = 1'b0;
    w_is_mul = 1'b0;
    case (in_mode)
      M_ADD, M_ADC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      M_SUB, M_SBB, M_CMP: begin
        w_res = (in_mode == M_CMP) ? in_a : w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      M_AND: w_res = in_a & in_b;
      M_OR:  w_res = in_a | in_b;
      M_XOR: w_res = in_a ^ in_b;
      M_NOT: w_res = ~in_a;
      M_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      M_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      M_SAR: begin
        w_res = w_sar[WIDTH:1];
        w_c   = w_sar[0];
      end
      M_MUL: begin
        if (MUL_EN != 0) w_is_mul = 1'b1;
        else             w_err    = 1'b1;
      end
      default: w_err = 1'b1;
    endcase
  end

  // CMP reports a==b and sign of the difference while passing a through.
  assign w_zn = (in_mode == M_CMP) ? w_diff[WIDTH-1:0] : w_res;

  // Right-shifting shift-add: low half starts as the multiplier and fills with product bits.
  assign w_mac      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_prod_nxt = {w_mac, r_prod[WIDTH-1:1]};
  assign w_mul_last = (r_state == S_MUL_BUSY) && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_is_mul ? S_MUL_BUSY : S_DONE;
      end
      S_MUL_BUSY: begin
        if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          if (w_accept) w_state_nxt = w_is_mul ? S_MUL_BUSY : S_DONE;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_hi         <= '0;
      r_err        <= 1'b0;
      r_flag_zero  <= 1'b0;
      r_flag_carry <= 1'b0;
      r_flag_neg   <= 1'b0;
      r_flag_ovf   <= 1'b0;
      r_prod       <= '0;
      r_mcand      <= '0;
      r_cnt        <= '0;
    end else if (w_accept && w_is_mul) begin
      r_prod  <= {{WIDTH{1'b0}}, in_b};
      r_mcand <= in_a;
      r_cnt   <= CNT_LOAD;
    end else if (w_accept) begin
      r_data <= w_err ? '0 : w_res;
      r_hi   <= '0;
      r_err  <= w_err;
      // Illegal modes leave the condition flags as they were.
      if (!w_err) begin
        r_flag_zero  <= (w_zn == '0);
        r_flag_carry <= w_c;
        r_flag_neg   <= w_zn[WIDTH-1];
        r_flag_ovf   <= w_v;
      end
    end else if (r_state == S_MUL_BUSY) begin
      r_prod <= w_prod_nxt;
      r_cnt  <= r_cnt - CNT_LAST;
      if (w_mul_last) begin
        r_data       <= w_prod_nxt[WIDTH-1:0];
        r_hi         <= w_prod_nxt[2*WIDTH-1:WIDTH];
        r_err        <= 1'b0;
        r_flag_zero  <= (w_prod_nxt == '0);
        r_flag_carry <= (w_prod_nxt[2*WIDTH-1:WIDTH] != '0);
        r_flag_neg   <= w_prod_nxt[2*WIDTH-1];
        r_flag_ovf   <= (w_prod_nxt[2*WIDTH-1:WIDTH] != '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: expected results queued at accept, compared on output handshake.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [W-1:0] out_hi;
  logic         out_err;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_neg;
  logic         flag_ovf;
  logic         busy;

  alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_hi     (out_hi),
    .out_err    (out_err),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_neg   (flag_neg),
    .flag_ovf   (flag_ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] dat;
    logic [7:0] hi;
    logic       err;
    logic       z;
    logic       c;
    logic       n;
    logic       v;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  exp_t mon_got;
  int   n_cmp = 0;
  int   n_err = 0;
  logic m_z, m_c, m_n, m_v;

  // Reference: integer arithmetic and bit-serial shifts, using the model's own flag state.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] mode);
    exp_t x;
    int ua, ub, sa, sbv, ci, r, sr;
    logic [7:0]  res, zn;
    logic [15:0] p;
    ua = int'(a);
    ub = int'(b);
    sa  = a[7] ? ua - 256 : ua;
    sbv = b[7] ? ub - 256 : ub;
    x.dat = 8'h00; x.hi = 8'h00; x.err = 1'b0;
    x.z = m_z; x.c = m_c; x.n = m_n; x.v = m_v;
    res = 8'h00;
    case (mode)
      4'd0, 4'd2: begin
        ci = (mode == 4'd2 && m_c) ? 1 : 0;
        r = ua + ub + ci;
        res = r[7:0];
        x.c = (r > 255);
        sr = sa + sbv + ci;
        x.v = (sr > 127) || (sr < -128);
      end
      4'd1, 4'd3, 4'd4: begin
        ci = (mode == 4'd3 && m_c) ? 1 : 0;
        r = ua - ub - ci;
        res = r[7:0];
        x.c = (r < 0);
        sr = sa - sbv - ci;
        x.v = (sr > 127) || (sr < -128);
      end
      4'd5: begin res = a & b; x.c = 0; x.v = 0; end
      4'd6: begin res = a | b; x.c = 0; x.v = 0; end
      4'd7: begin res = a ^ b; x.c = 0; x.v = 0; end
      4'd8: begin res = ~a;    x.c = 0; x.v = 0; end
      4'd9, 4'd10, 4'd11: begin
        res = a; x.c = 0; x.v = 0;
        for (int i = 0; i < int'(b[2:0]); i++) begin
          if (mode == 4'd9) begin x.c = res[7]; res = {res[6:0], 1'b0}; end
          else if (mode == 4'd10) begin x.c = res[0]; res = {1'b0, res[7:1]}; end
          else begin x.c = res[0]; res = {res[7], res[7:1]}; end
        end
      end
      4'd12: begin
        p = {8'h00, a} * {8'h00, b};
        x.dat = p[7:0];
        x.hi  = p[15:8];
        x.z   = (p == 16'h0000);
        x.n   = p[15];
        x.c   = (p[15:8] != 8'h00);
        x.v   = (p[15:8] != 8'h00);
        return x;
      end
      default: begin
        x.err = 1'b1;
        return x;
      end
    endcase
    zn = res;
    if (mode == 4'd4) res = a;
    x.dat = res;
    x.z = (zn == 8'h00);
    x.n = zn[7];
    return x;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got out_data=%h out_hi=%h, no result was due", out_data, out_hi);
      end else begin
        mon_x   = sb.pop_front();
        mon_got = {out_data, out_hi, out_err, flag_zero, flag_carry, flag_neg, flag_ovf};
        if (mon_got !== mon_x) begin
          n_err++;
          $display("FAIL sb_result: got d=%h hi=%h err=%b zcnv=%b%b%b%b, want d=%h hi=%h err=%b zcnv=%b%b%b%b",
                   mon_got.dat, mon_got.hi, mon_got.err, mon_got.z, mon_got.c, mon_got.n, mon_got.v,
                   mon_x.dat, mon_x.hi, mon_x.err, mon_x.z, mon_x.c, mon_x.n, mon_x.v);
        end
      end
    end
  end

  // Holds the request until accepted, then queues its expected result; returns 1 time unit after the accept edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] mode);
    bit   got;
    exp_t x;
    in_a = a; in_b = b; in_mode = mode; in_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: mode=%0d in_ready=%b, want 1", mode, in_ready);
    end else begin
      x = model(a, b, mode);
      sb.push_back(x);
      m_z = x.z; m_c = x.c; m_n = x.n; m_v = x.v;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({out_valid, busy, out_err, flag_zero, flag_carry, flag_neg, flag_ovf} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got v/b/e/zcnv=%b%b%b%b%b%b%b, want 0000000",
               out_valid, busy, out_err, flag_zero, flag_carry, flag_neg, flag_ovf);
    end
    n_cmp++;
    if ({out_data, out_hi} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_data: got %h_%h, want 0000", out_hi, out_data);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b, want 1", in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_adc();
    time t0;
    out_ready = 1'b1;
    send(8'hF0, 8'h20, 4'd0);
    t0 = $time;
    n_cmp++;
    if ({out_valid, out_data, flag_carry, flag_zero} !== {1'b1, 8'h10, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL add_first: got v=%b d=%h c=%b z=%b, want v=1 d=10 c=1 z=0", out_valid, out_data, flag_carry, flag_zero);
    end
    send(8'h00, 8'h00, 4'd2);
    n_cmp++;
    if ({out_valid, out_data, flag_carry, flag_zero} !== {1'b1, 8'h01, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL adc_chain: got v=%b d=%h c=%b z=%b, want v=1 d=01 c=0 z=0", out_valid, out_data, flag_carry, flag_zero);
    end
    n_cmp++;
    if ($time - t0 != 10) begin
      n_err++;
      $display("FAIL adc_latency: got %0t apart, want 10 (one cycle)", $time - t0);
    end
    drain();
  endtask

  task automatic test_sub_cmp();
    out_ready = 1'b1;
    send(8'h10, 8'h20, 4'd1);
    send(8'h80, 8'h01, 4'd1);
    n_cmp++;
    if ({out_data, flag_ovf, flag_carry} !== {8'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL sub_ovf: got d=%h v=%b c=%b, want d=7f v=1 c=0", out_data, flag_ovf, flag_carry);
    end
    send(8'h33, 8'h33, 4'd4);
    n_cmp++;
    if ({out_data, flag_zero, flag_carry} !== {8'h33, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL cmp_eq: got d=%h z=%b c=%b, want d=33 z=1 c=0", out_data, flag_zero, flag_carry);
    end
    drain();
  endtask

  task automatic test_mul();
    int  lat, busy_cnt;
    bit  ready_seen;
    out_ready = 1'b1;
    send(8'hFF, 8'hFF, 4'd12);
    lat = 0; busy_cnt = 0; ready_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (busy) busy_cnt++;
      if (in_ready) ready_seen = 1'b1;
    end
    n_cmp++;
    if (lat != 9 || !out_valid) begin
      n_err++;
      $display("FAIL mul_latency: got %0d cycles (out_valid=%b), want 9", lat, out_valid);
    end
    n_cmp++;
    if (busy_cnt != 8) begin
      n_err++;
      $display("FAIL mul_busy: got %0d busy cycles, want 8", busy_cnt);
    end
    n_cmp++;
    if (ready_seen) begin
      n_err++;
      $display("FAIL mul_ready: got in_ready=1 during multiply, want 0");
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(8'hAA, 8'hAA, 4'd7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({out_valid, out_data, flag_zero, in_ready} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: got v=%b d=%h z=%b rdy=%b, want v=1 d=00 z=1 rdy=0",
                 k, out_valid, out_data, flag_zero, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got in_ready=%b, want 1", in_ready);
    end
    drain();
  endtask

  task automatic test_shifts();
    out_ready = 1'b1;
    send(8'h5A, 8'h00, 4'd10);
    send(8'h80, 8'h03, 4'd11);
    send(8'h81, 8'h01, 4'd9);
    n_cmp++;
    if ({out_data, flag_carry} !== {8'h02, 1'b1}) begin
      n_err++;
      $display("FAIL shl: got d=%h c=%b, want d=02 c=1", out_data, flag_carry);
    end
    send(8'h12, 8'h34, 4'd14);
    n_cmp++;
    if ({out_err, out_data, out_hi, flag_carry, flag_zero} !== {1'b1, 8'h00, 8'h00, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL illegal: got err=%b d=%h hi=%h c=%b z=%b, want err=1 d=00 hi=00 c=1 z=0",
               out_err, out_data, out_hi, flag_carry, flag_zero);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 24; k++)
      send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
    drain();
  endtask

  task automatic test_reset_mul();
    bit stale;
    out_ready = 1'b1;
    send(8'hF0, 8'h20, 4'd0);
    drain();
    send(8'h0F, 8'h0B, 4'd12);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mul_busy: got busy=%b before reset, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, out_err, flag_zero, flag_carry, flag_neg, flag_ovf} !== 7'b0) begin
      n_err++;
      $display("FAIL rst_mul_ctrl: got v/b/e/zcnv=%b%b%b%b%b%b%b, want 0000000",
               out_valid, busy, out_err, flag_zero, flag_carry, flag_neg, flag_ovf);
    end
    n_cmp++;
    if ({out_data, out_hi} !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_mul_data: got %h_%h, want 0000", out_hi, out_data);
    end
    sb.delete();
    m_z = 0; m_c = 0; m_n = 0; m_v = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mul_ready: got %b, want 1", in_ready);
    end
    stale = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
    end
    n_cmp++;
    if (stale) begin
      n_err++;
      $display("FAIL rst_mul_stale: got out_valid/busy=1 after reset, want 0");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; out_ready = 1'b0;
    m_z = 0; m_c = 0; m_n = 0; m_v = 0;
    test_reset();
    test_add_adc();
    test_sub_cmp();
    test_mul();
    test_backpressure();
    test_shifts();
    test_back_to_back();
    test_reset_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
